// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode/funct constants, ALU command and branch-type encodings.
package mips_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_SLL = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA = 6'h03;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd1,
    EXE_AND = 4'd2,
    EXE_OR  = 4'd3,
    EXE_NOR = 4'd4,
    EXE_XOR = 4'd5,
    EXE_SLT = 4'd6,
    EXE_SLL = 4'd7,
    EXE_SRL = 4'd8,
    EXE_SRA = 4'd9,
    EXE_NOP = 4'd15
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JUMP = 2'b11
  } br_type_e;

  typedef struct packed {
    exe_cmd_e cmd;
    logic     imm_sel;
    logic     mem_read;
    logic     mem_write;
    logic     wb_en;
    br_type_e br;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two read ports with write-through bypass, one write port, R0 hardwired to zero.
module reg_file import mips_defs::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Same-cycle write is forwarded so ID sees the value being written back.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, decoder and load-use hazard detection.
module id_stage import mips_defs::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dest,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic        freeze,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] imm,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [4:0]  dest,
  output logic [3:0]  exe_cmd,
  output logic        imm_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        wb_en,
  output logic [1:0]  br_type
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            valid_q;

  // IF/ID register: flush beats freeze; a flush leaves the PC as-is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!freeze) begin
      pc_q    <= if_pc;
      instr_q <= if_instr;
      valid_q <= 1'b1;
    end
  end

  logic [OP_W-1:0]   op;
  logic [OP_W-1:0]   funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm16;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign imm16 = instr_q[15:0];
  assign funct = instr_q[5:0];

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (wb_we),
    .wa  (wb_dest),
    .wd  (wb_data)
  );

  ctrl_t             ctrl;
  logic [REG_AW-1:0] dest_d;
  logic [XLEN-1:0]   imm_d;
  logic              uses_rt;

  always_comb begin
    ctrl.cmd       = EXE_NOP;
    ctrl.imm_sel   = 1'b0;
    ctrl.mem_read  = 1'b0;
    ctrl.mem_write = 1'b0;
    ctrl.wb_en     = 1'b0;
    ctrl.br        = BR_NONE;
    dest_d         = '0;
    uses_rt        = 1'b0;
    imm_d          = {{16{imm16[15]}}, imm16};
    case (op)
      OP_RTYPE: begin
        uses_rt    = 1'b1;
        ctrl.wb_en = 1'b1;
        dest_d     = rd;
        case (funct)
          FN_ADD:  ctrl.cmd = EXE_ADD;
          FN_SUB:  ctrl.cmd = EXE_SUB;
          FN_AND:  ctrl.cmd = EXE_AND;
          FN_OR:   ctrl.cmd = EXE_OR;
          FN_XOR:  ctrl.cmd = EXE_XOR;
          FN_NOR:  ctrl.cmd = EXE_NOR;
          FN_SLT:  ctrl.cmd = EXE_SLT;
          FN_SLL:  ctrl.cmd = EXE_SLL;
          FN_SRL:  ctrl.cmd = EXE_SRL;
          FN_SRA:  ctrl.cmd = EXE_SRA;
          default: begin
            ctrl.wb_en = 1'b0;
            dest_d     = '0;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
        ctrl.imm_sel = 1'b1;
        ctrl.wb_en   = 1'b1;
        dest_d       = rt;
        case (op)
          OP_SLTI: ctrl.cmd = EXE_SLT;
          OP_ANDI: ctrl.cmd = EXE_AND;
          OP_ORI:  ctrl.cmd = EXE_OR;
          default: ctrl.cmd = EXE_ADD;
        endcase
        if (op == OP_ANDI || op == OP_ORI) imm_d = {16'h0000, imm16};
        ctrl.mem_read = (op == OP_LW);
      end
      OP_SW: begin
        ctrl.cmd       = EXE_ADD;
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.cmd = EXE_SUB;
        ctrl.br  = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
        uses_rt  = 1'b1;
      end
      OP_J: begin
        ctrl.br = BR_JUMP;
        imm_d   = {6'b0, instr_q[25:0]};
      end
      default: ;
    endcase
  end

  // Load-use: hold IF/ID and send a bubble down while the load is in EX.
  assign freeze = valid_q && ex_mem_read && (ex_dest != '0) &&
                  ((ex_dest == rs) || (uses_rt && ex_dest == rt));

  logic bubble;
  assign bubble = !valid_q || freeze;

  assign id_valid  = valid_q;
  assign id_pc     = pc_q;
  assign src1      = rs;
  assign src2      = rt;
  assign dest      = dest_d;
  assign imm       = imm_d;
  assign imm_sel   = ctrl.imm_sel;
  assign exe_cmd   = bubble ? 4'd0 : ctrl.cmd;
  assign br_type   = bubble ? 2'b00 : ctrl.br;
  assign mem_read  = !bubble && ctrl.mem_read;
  assign mem_write = !bubble && ctrl.mem_write;
  assign wb_en     = !bubble && ctrl.wb_en && (dest_d != '0);

endmodule
